// File: rtl/score_update_ctrl.sv
// Two-player score keeper: adds the granted player's spun value to its score
// through one bit-serial full adder, saturating to all-ones on carry-out.
module score_update_ctrl #(
    parameter int WIDTH = 17
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] spun0,
    input  logic [WIDTH-1:0] spun1,
    input  logic             clear_scores,
    output logic [1:0]       ack,
    output logic             busy,
    output logic             sat,
    output logic [WIDTH-1:0] score0,
    output logic [WIDTH-1:0] score1
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             grant_q, grant_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-2:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] score0_q, score0_d;
    logic [WIDTH-1:0] score1_q, score1_d;
    logic [1:0]       ack_q, ack_d;
    logic             sat_q, sat_d;

    logic             sum_bit;
    logic             carry_out;
    logic             gnt;
    logic [WIDTH-1:0] full_sum;
    logic [WIDTH-1:0] result;

    assign sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
    assign carry_out = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    // Earlier result bits sit in sum_q; the new bit enters at the top.
    assign full_sum  = {sum_bit, sum_q};
    assign result    = carry_out ? {WIDTH{1'b1}} : full_sum;
    assign gnt       = (req == 2'b11) ? ptr_q : req[1];

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        score0_d = score0_q;
        score1_d = score1_q;
        ack_d    = 2'b00;
        sat_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    grant_d = gnt;
                    a_d     = gnt ? score1_q : score0_q;
                    b_d     = gnt ? spun1 : spun0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = full_sum[WIDTH-1:1];
                carry_d = carry_out;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    if (grant_q) begin
                        score1_d = result;
                    end else begin
                        score0_d = result;
                    end
                    ack_d = grant_q ? 2'b10 : 2'b01;
                    sat_d = carry_out;
                    ptr_d = ~grant_q;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Clear wins over everything except the arbitration pointer.
        if (clear_scores) begin
            state_d  = IDLE;
            ptr_d    = ptr_q;
            score0_d = '0;
            score1_d = '0;
            ack_d    = 2'b00;
            sat_d    = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            grant_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            score0_q <= '0;
            score1_q <= '0;
            ack_q    <= 2'b00;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            score0_q <= score0_d;
            score1_q <= score1_d;
            ack_q    <= ack_d;
            sat_q    <= sat_d;
        end
    end

    assign ack    = ack_q;
    assign sat    = sat_q;
    assign busy   = (state_q != IDLE);
    assign score0 = score0_q;
    assign score1 = score1_q;

endmodule

// File: tb/tb_score_update_ctrl.sv
// Directed bench for score_update_ctrl: a table of operations with hand-computed
// results, then hand-written clear, clear-vs-grant and mid-operation reset cases.
module tb_score_update_ctrl;
    localparam int WIDTH = 17;

    logic             clock = 1'b0;
    logic             resetn = 1'b0;
    logic [1:0]       req = 2'b00;
    logic [WIDTH-1:0] spun0 = '0;
    logic [WIDTH-1:0] spun1 = '0;
    logic             clear_scores = 1'b0;
    logic [1:0]       ack;
    logic             busy;
    logic             sat;
    logic [WIDTH-1:0] score0;
    logic [WIDTH-1:0] score1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [1:0]       req;
        logic [WIDTH-1:0] spun0;
        logic [WIDTH-1:0] spun1;
        bit               drop;
        bit               hold;
        logic [1:0]       exp_ack;
        logic             exp_sat;
        logic [WIDTH-1:0] exp_s0;
        logic [WIDTH-1:0] exp_s1;
        int               exp_lat;
    } vec_t;

    vec_t vecs[9];

    score_update_ctrl #(.WIDTH(WIDTH)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .req          (req),
        .spun0        (spun0),
        .spun1        (spun1),
        .clear_scores (clear_scores),
        .ack          (ack),
        .busy         (busy),
        .sat          (sat),
        .score0       (score0),
        .score1       (score1)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Counts falling edges until ack appears; -1 means it never came.
    task automatic waitAck(input string name, input bit drop, output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (i == 1 && drop) req = 2'b00;
            if (i == 2) checkOutput({name, " busy"}, 32'(busy), 32'd1);
            if (ack !== 2'b00) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        int    lat;
        string nm;
        nm    = $sformatf("v%0d", idx);
        req   = v.req;
        spun0 = v.spun0;
        spun1 = v.spun1;
        waitAck(nm, v.drop, lat);
        checkOutput({nm, " latency"}, 32'(lat), 32'(v.exp_lat));
        checkOutput({nm, " ack"}, 32'(ack), 32'(v.exp_ack));
        checkOutput({nm, " sat"}, 32'(sat), 32'(v.exp_sat));
        checkOutput({nm, " score0"}, 32'(score0), 32'(v.exp_s0));
        checkOutput({nm, " score1"}, 32'(score1), 32'(v.exp_s1));
        if (!v.hold) begin
            req = 2'b00;
            @(negedge clock);
            checkOutput({nm, " ack pulse end"}, 32'(ack), 32'd0);
            checkOutput({nm, " sat pulse end"}, 32'(sat), 32'd0);
            @(negedge clock);
        end
    endtask

    initial begin
        int lat;

        //            req    spun0       spun1       drop  hold  ack    sat   score0      score1      lat
        vecs[0] = '{2'b01, 17'd100,    17'd0,      1'b0, 1'b0, 2'b01, 1'b0, 17'd100,    17'd0,      18};
        vecs[1] = '{2'b11, 17'd5,      17'd7,      1'b0, 1'b1, 2'b10, 1'b0, 17'd100,    17'd7,      18};
        vecs[2] = '{2'b11, 17'd5,      17'd7,      1'b0, 1'b0, 2'b01, 1'b0, 17'd105,    17'd7,      19};
        vecs[3] = '{2'b01, 17'h1FF87,  17'd0,      1'b1, 1'b0, 2'b01, 1'b0, 17'h1FFF0,  17'd7,      18};
        vecs[4] = '{2'b01, 17'h00020,  17'd0,      1'b0, 1'b0, 2'b01, 1'b1, 17'h1FFFF,  17'd7,      18};
        vecs[5] = '{2'b10, 17'd0,      17'h1FFF7,  1'b0, 1'b0, 2'b10, 1'b0, 17'h1FFFF,  17'h1FFFE,  18};
        vecs[6] = '{2'b10, 17'd0,      17'd1,      1'b0, 1'b0, 2'b10, 1'b0, 17'h1FFFF,  17'h1FFFF,  18};
        vecs[7] = '{2'b11, 17'd3,      17'd2,      1'b0, 1'b1, 2'b01, 1'b1, 17'h1FFFF,  17'h1FFFF,  18};
        vecs[8] = '{2'b11, 17'd3,      17'd2,      1'b0, 1'b0, 2'b10, 1'b1, 17'h1FFFF,  17'h1FFFF,  19};

        #1;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset ack", 32'(ack), 32'd0);
        checkOutput("reset score0", 32'(score0), 32'd0);
        checkOutput("reset score1", 32'(score1), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 9; i++) applyStimulus(i, vecs[i]);

        // Clear sampled at the eighth edge of an operation, request left high.
        req   = 2'b01;
        spun0 = 17'd4;
        repeat (8) @(negedge clock);
        clear_scores = 1'b1;
        @(negedge clock);
        clear_scores = 1'b0;
        checkOutput("clr busy", 32'(busy), 32'd0);
        checkOutput("clr ack", 32'(ack), 32'd0);
        checkOutput("clr sat", 32'(sat), 32'd0);
        checkOutput("clr score0", 32'(score0), 32'd0);
        checkOutput("clr score1", 32'(score1), 32'd0);
        waitAck("clr regrant", 1'b0, lat);
        checkOutput("clr regrant latency", 32'(lat), 32'd18);
        checkOutput("clr regrant ack", 32'(ack), 32'd1);
        checkOutput("clr regrant score0", 32'(score0), 32'd4);
        req = 2'b00;
        repeat (2) @(negedge clock);

        // Clear beats a grant in IDLE; pointer (now 1) must survive the clear.
        req          = 2'b11;
        spun0        = 17'd9;
        spun1        = 17'd6;
        clear_scores = 1'b1;
        @(negedge clock);
        clear_scores = 1'b0;
        checkOutput("prio busy", 32'(busy), 32'd0);
        checkOutput("prio score0", 32'(score0), 32'd0);
        waitAck("prio", 1'b0, lat);
        checkOutput("prio latency", 32'(lat), 32'd18);
        checkOutput("prio ack", 32'(ack), 32'd2);
        checkOutput("prio score0 kept", 32'(score0), 32'd0);
        checkOutput("prio score1", 32'(score1), 32'd6);
        req = 2'b00;
        repeat (2) @(negedge clock);

        // Short reset pulse between clock edges in the middle of ADD.
        req   = 2'b01;
        spun0 = 17'd50;
        repeat (5) @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        checkOutput("arst busy", 32'(busy), 32'd0);
        checkOutput("arst ack", 32'(ack), 32'd0);
        checkOutput("arst sat", 32'(sat), 32'd0);
        checkOutput("arst score1", 32'(score1), 32'd0);
        #1 resetn = 1'b1;
        waitAck("arst regrant", 1'b0, lat);
        checkOutput("arst regrant latency", 32'(lat), 32'd18);
        checkOutput("arst regrant ack", 32'(ack), 32'd1);
        checkOutput("arst regrant score0", 32'(score0), 32'd50);
        checkOutput("arst regrant score1", 32'(score1), 32'd0);
        req = 2'b00;
        repeat (2) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
